pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined RV32I core.
- Replaces the plain next-PC register in the fetch stage.
- Owns the architectural fetch PC, sequential increment, hazard stall, EX-stage redirect (branch/jump/trap) and a direct-mapped branch target buffer (BTB) that predicts taken control transfers.
- Feeds the instruction-memory address and the IF/ID pipeline register.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits, word-aligned).
- BTB_DEPTH, 8, number of BTB entries; power of two, at least 2.
- IDX_W, $clog2(BTB_DEPTH), derived BTB index width (localparam).

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- stall_i  in  1  hold the PC (load-use or memory hazard).
- redirect_i  in  1  EX-stage redirect request (resolved branch, jump, trap).
- redirect_pc_i  in  XLEN  redirect target.
- upd_en_i  in  1  BTB update strobe from EX on every resolved control instruction.
- upd_pc_i  in  XLEN  PC of the resolved control instruction.
- upd_target_i  in  XLEN  resolved target address.
- upd_taken_i  in  1  1 = taken, 0 = not taken.
- pc_o  out  XLEN  current fetch PC (registered).
- pc_valid_o  out  1  pc_o is a real fetch address.
- pred_taken_o  out  1  BTB predicts that pc_o is a taken transfer.
- pred_target_o  out  XLEN  predicted target, meaningful only when pred_taken_o = 1.
- misalign_o  out  1  registered one-cycle flag: last redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_ni = 0), taking effect immediately, including mid-operation:
  - pc_o = RESET_VEC, pc_valid_o = 0, misalign_o = 0.
  - All BTB valid bits cleared; state = BOOT.
  - pred_taken_o = 0 because pc_valid_o = 0.
- State machine:
  - BOOT: on the first rising edge with rst_ni = 1, pc_valid_o <= 1, pc_o stays RESET_VEC, state <= RUN. stall_i and redirect_i are ignored in BOOT.
  - RUN: next-PC priority, highest first:
    1. redirect_i
    2. stall_i
    3. BTB hit
    4. sequential
- RUN cases:
  - redirect_i = 1: pc_o <= {redirect_pc_i[XLEN-1:2], 2'b00}; misalign_o <= |redirect_pc_i[1:0]. Redirect overrides stall_i.
  - stall_i = 1 (no redirect): pc_o held, misalign_o <= 0.
  - pred_taken_o = 1: pc_o <= pred_target_o.
  - Otherwise: pc_o <= pc_o + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000).
  - misalign_o is 0 in every case except a misaligned redirect.
- BTB entry fields: valid bit, tag = pc[XLEN-1:IDX_W+2], target[XLEN-1:0].
- BTB lookup (combinational on pc_o):
  - idx = pc_o[IDX_W+1:2].
  - hit = valid[idx] & (tag[idx] == pc_o[XLEN-1:IDX_W+2]).
  - pred_taken_o = hit & pc_valid_o; pred_target_o = target[idx].
- BTB update (synchronous, at the edge where upd_en_i = 1, idx from upd_pc_i):
  - upd_taken_i = 1: valid <= 1, tag and target written; any previous entry at that index is overwritten.
  - upd_taken_i = 0: valid <= 0 only if the stored tag matches; otherwise the entry is untouched.
- Simultaneous events:
  - Update and lookup on the same index in the same cycle: the lookup uses the old contents; the new contents are visible from the next cycle.
  - An update is applied even when stall_i or redirect_i is high.
  - An update in BOOT is applied.
- Latency: one cycle from any input to pc_o; zero cycles from pc_o to the pred_* outputs.

Test Plan:
- Reset/boot: rst_ni = 0 with redirect_i = 1 and redirect_pc_i = 0x40 -> pc_o = 0, pc_valid_o = 0. Release reset -> after edge 1, pc_o = 0 and pc_valid_o = 1; after edge 2, pc_o = 4; after edge 3, pc_o = 8.
- Stall vs redirect: at pc_o = 0x10, stall_i = 1 for 3 cycles -> pc_o stays 0x10. Stall plus redirect_i to 0x200 -> pc_o = 0x200. Redirect to 0x203 -> pc_o = 0x200 and misalign_o = 1 for exactly one cycle.
- BTB train/predict: update pc = 0x24, target = 0x80, taken = 1; then redirect to 0x20 -> sequence is 0x20, 0x24 (pred_taken_o = 1, pred_target_o = 0x80), then 0x80.
- Aliasing/invalidate: with 0x24 trained, pc 0x44 (same index, different tag) -> pred_taken_o = 0. Not-taken update for 0x44 leaves the 0x24 entry valid. Not-taken update for 0x24 -> 0x24 no longer predicts.
- Same-cycle update/lookup: while pc_o = 0x24, train 0x24 -> pred_taken_o = 0 that cycle; the next visit to 0x24 predicts 0x80.
- Wrap and async reset: redirect to 0xFFFF_FFFC -> next pc_o = 0x0. Drop rst_ni mid-cycle -> pc_o = 0 and pc_valid_o = 0 before the next edge, and previously trained BTB entries no longer hit.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator for the pipelined RV32I fetch stage.
// Holds the fetch PC and steps it sequentially. It can hold the PC on a
// hazard stall and take EX-stage redirects. A direct-mapped branch target
// buffer predicts taken control transfers for the PC currently being fetched.
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = 32'h0000_0000,
  parameter int               BTB_DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            misalign_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [XLEN-1:0]   pc_r;
  logic              pc_valid_r;
  logic              misalign_r;

  logic              btb_valid_r  [BTB_DEPTH];
  logic [TAG_W-1:0]  btb_tag_r    [BTB_DEPTH];
  logic [XLEN-1:0]   btb_target_r [BTB_DEPTH];

  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              hit_s;
  logic              pred_taken_s;
  logic [XLEN-1:0]   pred_target_s;

  logic [IDX_W-1:0]  upd_idx_s;
  logic [TAG_W-1:0]  upd_tag_s;

  logic [XLEN-1:0]   next_pc_s;
  logic              next_misalign_s;

  // The low two bits of the update PC do not select an entry or form the tag.
  logic              unused_s;
  assign unused_s = ^upd_pc_i[1:0];

  // BTB lookup on the current fetch PC. This path is purely combinational.
  always_comb begin
    lk_idx_s      = pc_r[IDX_W+1:2];
    lk_tag_s      = pc_r[XLEN-1:IDX_W+2];
    hit_s         = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
    pred_target_s = btb_target_r[lk_idx_s];
    pred_taken_s  = hit_s & pc_valid_r;
  end

  // Select the next PC. A redirect wins over a stall, a stall wins over a
  // prediction, and a prediction wins over the sequential step.
  always_comb begin
    next_pc_s       = pc_r;
    next_misalign_s = 1'b0;
    if (redirect_i) begin
      next_pc_s       = {redirect_pc_i[XLEN-1:2], 2'b00};
      next_misalign_s = |redirect_pc_i[1:0];
    end else if (stall_i) begin
      next_pc_s       = pc_r;
      next_misalign_s = 1'b0;
    end else if (pred_taken_s) begin
      next_pc_s       = pred_target_s;
      next_misalign_s = 1'b0;
    end else begin
      next_pc_s       = pc_r + XLEN'(32'd4);
      next_misalign_s = 1'b0;
    end
  end

  // Fetch FSM. BOOT spends one cycle marking RESET_VEC as valid. RUN then
  // follows the next-PC selection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_VEC;
      pc_valid_r <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r    <= ST_RUN;
          pc_r       <= RESET_VEC;
          pc_valid_r <= 1'b1;
          misalign_r <= 1'b0;
        end
        ST_RUN: begin
          state_r    <= ST_RUN;
          pc_r       <= next_pc_s;
          pc_valid_r <= 1'b1;
          misalign_r <= next_misalign_s;
        end
        default: begin
          state_r    <= ST_BOOT;
          pc_r       <= RESET_VEC;
          pc_valid_r <= 1'b0;
          misalign_r <= 1'b0;
        end
      endcase
    end
  end

  // Split the update PC into a BTB index and a tag.
  always_comb begin
    upd_idx_s = upd_pc_i[IDX_W+1:2];
    upd_tag_s = upd_pc_i[XLEN-1:IDX_W+2];
  end

  // BTB write port. A taken update overwrites the entry. A not-taken update
  // invalidates the entry only when the entry belongs to the same PC.
  // Lookups in the same cycle still see the old contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_tag_r[i]    <= {TAG_W{1'b0}};
        btb_target_r[i] <= {XLEN{1'b0}};
      end
    end else if (upd_en_i) begin
      if (upd_taken_i) begin
        btb_valid_r[upd_idx_s]  <= 1'b1;
        btb_tag_r[upd_idx_s]    <= upd_tag_s;
        btb_target_r[upd_idx_s] <= upd_target_i;
      end else if (btb_tag_r[upd_idx_s] == upd_tag_s) begin
        btb_valid_r[upd_idx_s] <= 1'b0;
      end else begin
        btb_valid_r[upd_idx_s] <= btb_valid_r[upd_idx_s];
      end
    end else begin
      btb_valid_r[upd_idx_s] <= btb_valid_r[upd_idx_s];
    end
  end

  assign pc_o          = pc_r;
  assign pc_valid_o    = pc_valid_r;
  assign misalign_o    = misalign_r;
  assign pred_taken_o  = pred_taken_s;
  assign pred_target_o = pred_target_s;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen. Each step pushes the expected PC and flags
// into a queue. After the clock edge the step pops that entry and compares it
// against the DUT outputs.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        upd_en_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        upd;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pv;
    logic        pt;
    logic        mis;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_0000), .BTB_DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .upd_en_i(upd_en_i), .upd_pc_i(upd_pc_i),
    .upd_target_i(upd_target_i), .upd_taken_i(upd_taken_i), .pc_o(pc_o),
    .pc_valid_o(pc_valid_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  function automatic stim_t s(logic st, logic rd, logic [31:0] rpc);
    return '{st, rd, rpc, 1'b0, 32'h0, 32'h0, 1'b0};
  endfunction

  function automatic stim_t su(logic st, logic [31:0] upc, logic [31:0] tgt, logic tk);
    return '{st, 1'b0, 32'h0, 1'b1, upc, tgt, tk};
  endfunction

  function automatic exp_t ex(logic [31:0] pc, logic pv, logic pt, logic mis, logic [31:0] tgt);
    return '{pc, pv, pt, mis, tgt};
  endfunction

  task automatic apply(input stim_t x);
    stall_i       = x.stall;
    redirect_i    = x.redir;
    redirect_pc_i = x.rpc;
    upd_en_i      = x.upd;
    upd_pc_i      = x.upc;
    upd_target_i  = x.utgt;
    upd_taken_i   = x.utk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    rst_ni = 1'b0;
    apply(s(1'b0, 1'b1, 32'h40));
    repeat (3) tick();
    exp_q.push_back(ex(32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    e = exp_q.pop_front();
    total++;
    if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
      bad++;
      $display("FAIL reset_hold: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
               pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
    end
    rst_ni = 1'b1;
    st.push_back(s(1'b0, 1'b1, 32'h40)); exp_q.push_back(ex(32'h00, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h04, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h08, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h0C, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h10, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL boot step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
    end
  endtask

  task automatic test_stall_redirect();
    stim_t st[$];
    exp_t  e;
    st.push_back(s(1'b1, 1'b0, 32'h0));   exp_q.push_back(ex(32'h010, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b1, 1'b0, 32'h0));   exp_q.push_back(ex(32'h010, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b1, 1'b0, 32'h0));   exp_q.push_back(ex(32'h010, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b1, 1'b1, 32'h200)); exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b1, 32'h203)); exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 1'b1, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));   exp_q.push_back(ex(32'h204, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL stall_redirect step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
    end
  endtask

  task automatic test_btb_train();
    stim_t st[$];
    exp_t  e;
    st.push_back(su(1'b0, 32'h24, 32'h80, 1'b1)); exp_q.push_back(ex(32'h208, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b1, 32'h20));          exp_q.push_back(ex(32'h020, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));           exp_q.push_back(ex(32'h024, 1'b1, 1'b1, 1'b0, 32'h80));
    st.push_back(s(1'b0, 1'b0, 32'h0));           exp_q.push_back(ex(32'h080, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));           exp_q.push_back(ex(32'h084, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL btb_train step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
      if (e.pt) begin
        total++;
        if (pred_target_o !== e.tgt) begin
          bad++;
          $display("FAIL btb_train_target step %0d: got %h, expected %h", i, pred_target_o, e.tgt);
        end
      end
    end
  endtask

  task automatic test_alias_invalidate();
    stim_t st[$];
    exp_t  e;
    st.push_back(s(1'b0, 1'b1, 32'h44));          exp_q.push_back(ex(32'h44, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(su(1'b1, 32'h44, 32'h0, 1'b0));  exp_q.push_back(ex(32'h44, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b1, 32'h24));          exp_q.push_back(ex(32'h24, 1'b1, 1'b1, 1'b0, 32'h80));
    st.push_back(su(1'b1, 32'h24, 32'h0, 1'b0));  exp_q.push_back(ex(32'h24, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));           exp_q.push_back(ex(32'h28, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL alias step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
      if (e.pt) begin
        total++;
        if (pred_target_o !== e.tgt) begin
          bad++;
          $display("FAIL alias_target step %0d: got %h, expected %h", i, pred_target_o, e.tgt);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    stim_t st[$];
    exp_t  e;
    apply(s(1'b0, 1'b1, 32'h24));
    tick();
    exp_q.push_back(ex(32'h24, 1'b1, 1'b0, 1'b0, 32'h0));
    // Train 0x24 while it is being looked up. This cycle must still miss.
    apply(su(1'b0, 32'h24, 32'h80, 1'b1));
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
      bad++;
      $display("FAIL same_cycle_lookup: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
               pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
    end
    tick();
    exp_q.push_back(ex(32'h28, 1'b1, 1'b0, 1'b0, 32'h0));
    e = exp_q.pop_front();
    total++;
    if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
      bad++;
      $display("FAIL same_cycle_next: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
               pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
    end
    st.push_back(s(1'b0, 1'b1, 32'h24)); exp_q.push_back(ex(32'h24, 1'b1, 1'b1, 1'b0, 32'h80));
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h80, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL same_cycle_revisit step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
      if (e.pt) begin
        total++;
        if (pred_target_o !== e.tgt) begin
          bad++;
          $display("FAIL same_cycle_target step %0d: got %h, expected %h", i, pred_target_o, e.tgt);
        end
      end
    end
  endtask

  task automatic test_wrap_async_reset();
    stim_t st[$];
    exp_t  e;
    st.push_back(s(1'b0, 1'b1, 32'hFFFF_FFFC)); exp_q.push_back(ex(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));         exp_q.push_back(ex(32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));         exp_q.push_back(ex(32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL wrap step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
    end
    // Assert reset in the middle of a cycle. Its effect must appear before the next edge.
    #2 rst_ni = 1'b0;
    #1;
    exp_q.push_back(ex(32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    e = exp_q.pop_front();
    total++;
    if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
      bad++;
      $display("FAIL async_reset: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
               pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
    end
    #1 rst_ni = 1'b1;
    st.delete();
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h00, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b1, 32'h24)); exp_q.push_back(ex(32'h24, 1'b1, 1'b0, 1'b0, 32'h0));
    st.push_back(s(1'b0, 1'b0, 32'h0));  exp_q.push_back(ex(32'h28, 1'b1, 1'b0, 1'b0, 32'h0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      tick();
      e = exp_q.pop_front();
      total++;
      if ({pc_o, pc_valid_o, pred_taken_o, misalign_o} !== {e.pc, e.pv, e.pt, e.mis}) begin
        bad++;
        $display("FAIL post_reset step %0d: got pc=%h v=%b pt=%b mis=%b, expected pc=%h v=%b pt=%b mis=%b",
                 i, pc_o, pc_valid_o, pred_taken_o, misalign_o, e.pc, e.pv, e.pt, e.mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_btb_train();
    test_alias_invalidate();
    test_same_cycle();
    test_wrap_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
